// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared state encoding, Booth bit-pair codes and iteration
//               counter width helper for the Booth multiplier sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  // {Q[0], Q[-1]} decode
  localparam logic [1:0] BP_NOP0 = 2'b00;
  localparam logic [1:0] BP_ADD  = 2'b01;
  localparam logic [1:0] BP_SUB  = 2'b10;
  localparam logic [1:0] BP_NOP1 = 2'b11;

  function automatic int iter_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_iter_cnt.sv
`default_nettype none
// ============================================================================
// Module      : booth_iter_cnt
// Description : Loadable down-counter of remaining Booth iterations with a
//               last-iteration flag. Saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_iter_cnt
  import booth_pkg::*;
#(
  parameter int W = iter_w(4)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == W'(1));

endmodule
`default_nettype wire

// File: rtl/booth_control.sv
`default_nettype none
// ============================================================================
// Module      : booth_control
// Description : Sequencing FSM for a radix-2 Booth multiplier datapath:
//               load, then ancho evaluate/shift rounds, then a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_control
  import booth_pkg::*;
#(
  parameter int ancho = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                booth_pair,
  output logic                      load,
  output logic                      op_add,
  output logic                      op_sub,
  output logic                      shift,
  output logic                      busy,
  output logic                      done,
  output logic                      result_valid,
  output logic [iter_w(ancho)-1:0]  iter
);

  localparam int                    c_iter_w    = iter_w(ancho);
  localparam logic [c_iter_w-1:0]   c_iter_init = c_iter_w'(ancho);

  state_t r_state;
  state_t w_next;
  logic   r_result_valid;
  logic   w_busy;
  logic   w_accept;
  logic   w_abort;
  logic   w_cnt_dec;
  logic   w_last;

  assign w_busy    = (r_state == LOAD) || (r_state == EVAL) || (r_state == SHIFT);
  assign w_accept  = (r_state == IDLE) && start;
  assign w_abort   = w_busy && abort;
  assign w_cnt_dec = (r_state == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = abort ? IDLE : EVAL;
      EVAL:    w_next = abort ? IDLE : SHIFT;
      SHIFT: begin
        if (abort)       w_next = IDLE;
        else if (w_last) w_next = DONE;
        else             w_next = EVAL;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Cleared when a new operation is accepted, so an abort leaves it low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result_valid <= 1'b0;
    end else if (w_accept) begin
      r_result_valid <= 1'b0;
    end else if (r_state == DONE) begin
      r_result_valid <= 1'b1;
    end
  end

  booth_iter_cnt #(
    .W (c_iter_w)
  ) u_iter_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_accept),
    .dec      (w_cnt_dec),
    .clear    (w_abort),
    .load_val (c_iter_init),
    .cnt      (iter),
    .last     (w_last)
  );

  assign load         = (r_state == LOAD);
  assign shift        = (r_state == SHIFT);
  assign busy         = w_busy;
  assign done         = (r_state == DONE);
  assign op_add       = (r_state == EVAL) && (booth_pair == BP_ADD);
  assign op_sub       = (r_state == EVAL) && (booth_pair == BP_SUB);
  assign result_valid = r_result_valid;

  a_ctrl_onehot : assert property (@(posedge clk) disable iff (!rst)
    $onehot0({load, op_add, op_sub, shift}));

endmodule
`default_nettype wire
